alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 64: operand/result width, matching the 64-bit ALU datapath.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have ports req_valid_0 / req_valid_1  input  1 each  requester i has an operation pending.
REQ-005 SHALL have ports req_ready_0 / req_ready_1  output  1 each  requester i's operation accepted this cycle when valid and ready are both high.
REQ-006 SHALL have ports req_A_0, req_B_0, req_A_1, req_B_1  input  WIDTH each  operands.
REQ-007 SHALL have ports req_cntrl_0 / req_cntrl_1  input  3 each  ALU control code, passed through unchecked.
REQ-008 SHALL have ports req_lock_0 / req_lock_1  input  1 each  lock request, used only under ALU_ARB_LOCK_EN.
REQ-009 SHALL have ports alu_A, alu_B  output  WIDTH  and alu_cntrl  output  3  driving the external combinational ALU.
REQ-010 SHALL have ports alu_result  input  WIDTH  and alu_negative, alu_zero, alu_overflow, alu_carry_out  input  1 each  from the ALU.
REQ-011 SHALL have ports resp_valid  output  1, resp_ready  input  1, resp_id  output  1 (requester index), resp_result  output  WIDTH, resp_flags  output  4 ({negative, zero, overflow, carry_out}).

Function
REQ-012 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-013 In IDLE, req_ready_i SHALL be high only for the granted requester i, and only when req_valid_i is high; all req_ready SHALL be low in EXEC and RESP.
REQ-014 Grant SHALL be round-robin: a sole valid requester wins; with both valid, the requester not served last wins.
REQ-015 On acceptance (IDLE), the block SHALL register A, B, cntrl and the requester id, record the id as last-served, and move to EXEC.
REQ-016 alu_A, alu_B, alu_cntrl SHALL be driven only from these registers, holding their values from acceptance until the next acceptance.
REQ-017 In EXEC (exactly one cycle), the block SHALL capture alu_result and the four flags into resp_result and resp_flags at the clock edge, then move to RESP.
REQ-018 In RESP, resp_valid SHALL be high; resp_id, resp_result and resp_flags SHALL remain stable until resp_ready is sampled high.
REQ-019 On resp_valid && resp_ready, the block SHALL return to IDLE; a new request SHALL NOT be accepted in that same cycle.
REQ-020 Latency SHALL be: accept at edge N, resp_valid high from cycle N+2; the minimum issue interval is 3 cycles.
REQ-021 resp_ready held low SHALL stall indefinitely without loss or corruption of the response.
REQ-022 A requester dropping req_valid before acceptance SHALL cause no side effects.

Reset
REQ-023 While reset_n is low at a clock edge, state SHALL go to IDLE, resp_valid to 0, req_ready outputs to 0, and resp_result, resp_flags, resp_id, alu_A, alu_B, alu_cntrl to 0.
REQ-024 After reset, last-served SHALL be 1, so requester 0 wins the first contended arbitration.
REQ-025 Reset asserted in EXEC or RESP SHALL discard the in-flight operation; no response for it SHALL appear after reset releases.

Configuration
REQ-026 With macro ALU_ARB_LOCK_EN defined, an accepted request with req_lock_i=1 SHALL give requester i priority at the next IDLE arbitration if req_valid_i is high there, overriding round-robin; otherwise normal round-robin SHALL apply.
REQ-027 Without ALU_ARB_LOCK_EN, req_lock_* SHALL be ignored and arbitration SHALL be pure round-robin.

Verification
REQ-028 Single request, reqs 0: A=5, B=3, add cntrl -> resp_valid at N+2, resp_id=0, resp_result=8, zero flag=0.
REQ-029 Both requesters valid continuously after reset -> grants alternate 0,1,0,1 across four operations.
REQ-030 Subtract A=7, B=7 on requester 1 -> resp_result=0, zero=1, negative=0; then subtract A=0, B=1 -> result all ones, negative=1.
REQ-031 resp_ready held low for 10 cycles in RESP -> resp fields constant, both req_ready low throughout, no acceptance until the response is taken.
REQ-032 reset_n pulsed low for one cycle during EXEC -> resp_valid stays 0, all outputs 0, next contended request goes to requester 0.
REQ-033 With ALU_ARB_LOCK_EN defined, requester 0 issues three locked operations with requester 1 also valid -> requester 0 is served three times before requester 1; with the macro undefined, service alternates.

Source files
------------

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Two-requester front end for a shared external combinational ALU. One
//   operation is in flight at a time: IDLE accepts a request, EXEC captures
//   the ALU outputs one cycle later, and RESP holds the response until the
//   consumer takes it. Grant is round-robin. Requester 0 wins the first
//   contended grant after reset.
//
//   Optional feature: define ALU_ARB_LOCK_EN to let an accepted request that
//   carries req_lock_i=1 give requester i priority at the next arbitration.
//
// Ports
//   clk, reset_n                   clock, synchronous active-low reset
//   req_valid_i / req_ready_i      per-requester handshake (i = 0, 1)
//   req_A_i, req_B_i, req_cntrl_i  per-requester operands and ALU control
//   req_lock_i                     lock request (ALU_ARB_LOCK_EN only)
//   alu_A, alu_B, alu_cntrl        registered drive to the external ALU
//   alu_result, alu_negative, alu_zero, alu_overflow, alu_carry_out
//                                  outputs returned by the external ALU
//   resp_valid / resp_ready        response handshake
//   resp_id                        index of the requester being answered
//   resp_result                    captured ALU result
//   resp_flags                     {negative, zero, overflow, carry_out}
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid_0,
    input  logic             req_valid_1,
    output logic             req_ready_0,
    output logic             req_ready_1,
    input  logic [WIDTH-1:0] req_A_0,
    input  logic [WIDTH-1:0] req_B_0,
    input  logic [WIDTH-1:0] req_A_1,
    input  logic [WIDTH-1:0] req_B_1,
    input  logic [2:0]       req_cntrl_0,
    input  logic [2:0]       req_cntrl_1,
    input  logic             req_lock_0,
    input  logic             req_lock_1,
    output logic [WIDTH-1:0] alu_A,
    output logic [WIDTH-1:0] alu_B,
    output logic [2:0]       alu_cntrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_negative,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    input  logic             alu_carry_out,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_result,
    output logic [3:0]       resp_flags
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_last;          // requester served most recently
    logic             r_id;            // requester of the operation in flight
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_cntrl;
    logic             r_resp_valid;
    logic             r_resp_id;
    logic [WIDTH-1:0] r_resp_result;
    logic [3:0]       r_resp_flags;

    logic             w_grant_id;
    logic             w_idle;
    logic             w_accept;
    logic             w_take;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic [2:0]       w_sel_cntrl;
    logic             w_sel_lock;

`ifdef ALU_ARB_LOCK_EN
    logic             r_lock_pend;     // last accepted request asked for a lock
    logic             r_lock_id;       // requester that holds the lock
    logic             w_unused_lock;
    assign w_unused_lock = w_sel_lock;
`else
    // Lock inputs have no effect in the round-robin-only build.
    logic             w_unused_lock;
    assign w_unused_lock = w_sel_lock;
`endif

    // Arbitration: a sole valid requester wins; a contended grant goes to the
    // lock holder when one is pending, otherwise to the requester not served last.
    always_comb begin
        w_grant_id = 1'b0;
        if (req_valid_0 && req_valid_1) begin
`ifdef ALU_ARB_LOCK_EN
            if (r_lock_pend) begin
                w_grant_id = r_lock_id;
            end else begin
                w_grant_id = ~r_last;
            end
`else
            w_grant_id = ~r_last;
`endif
        end else if (req_valid_1) begin
            w_grant_id = 1'b1;
        end else begin
            w_grant_id = 1'b0;
        end
    end

    // Ready is gated by reset_n so nothing is offered while reset is applied.
    assign w_idle      = (r_state == ST_IDLE) && reset_n;
    assign req_ready_0 = w_idle && req_valid_0 && !w_grant_id;
    assign req_ready_1 = w_idle && req_valid_1 &&  w_grant_id;
    assign w_accept    = req_ready_0 || req_ready_1;
    assign w_take      = r_resp_valid && resp_ready;

    // Operand selection for the granted requester.
    always_comb begin
        w_sel_a     = req_A_0;
        w_sel_b     = req_B_0;
        w_sel_cntrl = req_cntrl_0;
        w_sel_lock  = req_lock_0;
        if (w_grant_id) begin
            w_sel_a     = req_A_1;
            w_sel_b     = req_B_1;
            w_sel_cntrl = req_cntrl_1;
            w_sel_lock  = req_lock_1;
        end else begin
            w_sel_a     = req_A_0;
            w_sel_b     = req_B_0;
            w_sel_cntrl = req_cntrl_0;
            w_sel_lock  = req_lock_0;
        end
    end

    // Next-state logic: EXEC lasts exactly one cycle; RESP waits for the taker.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_EXEC;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (w_take) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, operand and response registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_last        <= 1'b1;
            r_id          <= 1'b0;
            r_a           <= {WIDTH{1'b0}};
            r_b           <= {WIDTH{1'b0}};
            r_cntrl       <= 3'b000;
            r_resp_valid  <= 1'b0;
            r_resp_id     <= 1'b0;
            r_resp_result <= {WIDTH{1'b0}};
            r_resp_flags  <= 4'b0000;
`ifdef ALU_ARB_LOCK_EN
            r_lock_pend   <= 1'b0;
            r_lock_id     <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_a     <= w_sel_a;
                r_b     <= w_sel_b;
                r_cntrl <= w_sel_cntrl;
                r_id    <= w_grant_id;
                r_last  <= w_grant_id;
`ifdef ALU_ARB_LOCK_EN
                // Each acceptance replaces any earlier lock.
                r_lock_pend <= w_sel_lock;
                r_lock_id   <= w_grant_id;
`endif
            end
            if (r_state == ST_EXEC) begin
                r_resp_result <= alu_result;
                r_resp_flags  <= {alu_negative, alu_zero, alu_overflow, alu_carry_out};
                r_resp_id     <= r_id;
                r_resp_valid  <= 1'b1;
            end else if (w_take) begin
                r_resp_valid  <= 1'b0;
            end
        end
    end

    assign alu_A       = r_a;
    assign alu_B       = r_b;
    assign alu_cntrl   = r_cntrl;
    assign resp_valid  = r_resp_valid;
    assign resp_id     = r_resp_id;
    assign resp_result = r_resp_result;
    assign resp_flags  = r_resp_flags;

endmodule
